// File: rtl/pad_cfg_apb_regs.sv
// pad_cfg_apb_regs
//   APB3 slave register file that drives the per-pad configuration vector for
//   the pad frame. It also captures the two bootsel pads once after reset and
//   exposes them as a frozen status. A sticky lock bit write-protects the pad
//   configuration until the next reset.
//
// Ports
//   clk_i, rst_ni      system clock, asynchronous active-low reset
//   PADDR..PENABLE     APB3 request (only PADDR[7:2] decoded)
//   PRDATA/PREADY/     APB3 response, all registered
//   PSLVERR
//   bootsel_i          raw bootsel pads (asynchronous)
//   pad_cfg_o          per-pad 6-bit config, pad p at pad_cfg_o[p]
//   bootsel_o          captured boot select
//   bootsel_valid_o    high once bootsel_o has been captured
//   cfg_locked_o       high when pad config writes are blocked
//
// Handshake: an access (PSEL & PENABLE) with PREADY low gets PREADY=1 with
// PRDATA/PSLVERR on the following cycle, giving exactly one wait state. The
// register write commits on the edge that ends the PREADY=1 cycle, and PREADY
// then drops, so back-to-back transfers each pay the wait state.

module pad_cfg_apb_regs #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_PADS         = 48,
  parameter int BOOT_SETTLE    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [1:0]                bootsel_i,
  output logic [N_PADS-1:0][5:0]    pad_cfg_o,
  output logic [1:0]                bootsel_o,
  output logic                      bootsel_valid_o,
  output logic                      cfg_locked_o
);

  localparam int N_REGS = N_PADS / 4;
  localparam logic [5:0] OFF_BOOT = 6'h10;  // byte address 0x40
  localparam logic [5:0] OFF_LOCK = 6'h11;  // byte address 0x44
  localparam int CNT_W = $clog2(BOOT_SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(BOOT_SETTLE);

  logic [5:0]  off;
  logic        access;
  logic        is_pad;
  logic [31:0] rd_data;
  logic        err;

  assign off    = PADDR[7:2];
  assign access = PSEL & PENABLE;
  assign is_pad = (int'(off) < N_REGS);

  // Address bits outside [7:2] and the unused write-data bits are ignored.
  logic unused_bits;
  assign unused_bits = ^{PADDR, PWDATA};

  // Read mux: PADCFG words zero-extend each 6-bit lane.
  always_comb begin
    rd_data = '0;
    if (is_pad) begin
      for (int k = 0; k < N_REGS; k++) begin
        if (off == 6'(k)) begin
          for (int b = 0; b < 4; b++) begin
            rd_data[8*b +: 6] = pad_cfg_o[4*k + b];
          end
        end
      end
    end else if (off == OFF_BOOT) begin
      rd_data[1:0] = bootsel_o;
      rd_data[8]   = bootsel_valid_o;
    end else if (off == OFF_LOCK) begin
      rd_data[0] = cfg_locked_o;
    end
  end

  // Error decode. The lock cannot change during a transfer, so the value
  // computed in the wait-state cycle still holds at the commit edge.
  always_comb begin
    err = 1'b0;
    if (is_pad) begin
      err = PWRITE & cfg_locked_o;
    end else if (off == OFF_BOOT) begin
      err = PWRITE;
    end else if (off != OFF_LOCK) begin
      err = 1'b1;
    end
  end

  // APB response and register writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      PREADY       <= 1'b0;
      PSLVERR      <= 1'b0;
      PRDATA       <= '0;
      pad_cfg_o    <= '0;
      cfg_locked_o <= 1'b0;
    end else begin
      if (access && !PREADY) begin
        PREADY  <= 1'b1;
        PSLVERR <= err;
        PRDATA  <= PWRITE ? 32'h0 : rd_data;
      end else begin
        PREADY  <= 1'b0;
        PSLVERR <= 1'b0;
        PRDATA  <= '0;
      end

      if (access && PREADY && PWRITE && !err) begin
        if (off == OFF_LOCK && PWDATA[0]) begin
          cfg_locked_o <= 1'b1;
        end
        for (int k = 0; k < N_REGS; k++) begin
          if (is_pad && off == 6'(k)) begin
            for (int b = 0; b < 4; b++) begin
              pad_cfg_o[4*k + b] <= PWDATA[8*b +: 6];
            end
          end
        end
      end
    end
  end

  // Bootsel capture. The settle counter starts one cycle after reset release
  // (started), so capture lands 2+BOOT_SETTLE edges after rst_ni rises, by
  // which point the synchronizer has long been filled with real pad values.
  logic [1:0]       sync1, sync2;
  logic             started;
  logic [CNT_W-1:0] settle_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1           <= '0;
      sync2           <= '0;
      started         <= 1'b0;
      settle_cnt      <= '0;
      bootsel_o       <= '0;
      bootsel_valid_o <= 1'b0;
    end else begin
      sync1   <= bootsel_i;
      sync2   <= sync1;
      started <= 1'b1;
      if (started && settle_cnt != SETTLE_VAL) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (settle_cnt == SETTLE_VAL && !bootsel_valid_o) begin
        bootsel_o       <= sync2;
        bootsel_valid_o <= 1'b1;
      end
    end
  end

endmodule
